multicycle_control: RTL

- Multicycle control FSM for the RISC-V core. Replaces the single-cycle opcode decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Decodes OP_i from the instruction register, holds on a memory ready handshake, and traps on illegal opcodes or memory timeouts.
- Sits between the instruction register / memory interface and the multicycle datapath (PC, IR, ALUOut, MDR registers).

---
 rtl/multicycle_control.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: fetch/decode/execute/memory/writeback sequencing with traps.
// Optional retired-instruction counter enabled by defining CONTROL_PERF_CNT_EN.
module multicycle_control #(
  parameter int ALU_OP_WIDTH   = 3,
  parameter int WAIT_CNT_WIDTH = 4,
  parameter int MAX_WAIT       = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              OP_i,
  input  logic                    Mem_Ready_i,
  output logic                    PC_Write_o,
  output logic                    IR_Write_o,
  output logic                    Mem_Read_o,
  output logic                    Mem_Write_o,
  output logic                    Reg_Write_o,
  output logic [1:0]              Wb_Sel_o,
  output logic [1:0]              ALU_Src_A_o,
  output logic [1:0]              ALU_Src_B_o,
  output logic [ALU_OP_WIDTH-1:0] ALU_Op_o,
  output logic [1:0]              PC_Src_o,
  output logic                    Branch_o,
  output logic                    Illegal_o,
  output logic                    Timeout_o,
  output logic [3:0]              State_o,
  output logic [31:0]             Instr_Count_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_EXEC_U = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_MEM_WB = 4'd8,
    S_ALU_WB = 4'd9,
    S_BRANCH = 4'd10,
    S_JAL    = 4'd11,
    S_JALR   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_R   = ALU_OP_WIDTH'(3'b000);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_IL  = ALU_OP_WIDTH'(3'b001);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_U   = ALU_OP_WIDTH'(3'b010);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = ALU_OP_WIDTH'(3'b011);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_BR  = ALU_OP_WIDTH'(3'b100);

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LIMIT = WAIT_CNT_WIDTH'(MAX_WAIT);

  typedef struct packed {
    logic                    is_fetch;
    logic                    pc_write;
    logic                    mem_read;
    logic                    mem_write;
    logic                    reg_write;
    logic                    branch;
    logic [1:0]              wb_sel;
    logic [1:0]              src_a;
    logic [1:0]              src_b;
    logic [1:0]              pc_src;
    logic [ALU_OP_WIDTH-1:0] alu_op;
  } ctrl_t;

  state_t                    state;
  state_t                    next_state;
  ctrl_t                     ctrl_q;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
  logic                      mem_wait;
  logic                      set_illegal;
  logic                      set_timeout;
  logic                      illegal_q;
  logic                      timeout_q;

  // Moore strobe table; FETCH's IR/PC loads are qualified by ready outside the register.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.is_fetch = 1'b1;
        c.mem_read = 1'b1;
        c.src_a    = 2'b00;
        c.src_b    = 2'b01;
        c.alu_op   = ALU_ADD;
      end
      S_DECODE: begin
        c.src_a  = 2'b10;
        c.src_b  = 2'b10;
        c.alu_op = ALU_ADD;
      end
      S_EXEC_R: begin
        c.src_a  = 2'b01;
        c.src_b  = 2'b00;
        c.alu_op = ALU_R;
      end
      S_EXEC_I: begin
        c.src_a  = 2'b01;
        c.src_b  = 2'b10;
        c.alu_op = ALU_IL;
      end
      S_EXEC_U: begin
        c.src_b  = 2'b10;
        c.alu_op = ALU_U;
      end
      S_ADDR: begin
        c.src_a  = 2'b01;
        c.src_b  = 2'b10;
        c.alu_op = ALU_ADD;
      end
      S_MEM_RD: c.mem_read  = 1'b1;
      S_MEM_WR: c.mem_write = 1'b1;
      S_MEM_WB: begin
        c.reg_write = 1'b1;
        c.wb_sel    = 2'b01;
      end
      S_ALU_WB: begin
        c.reg_write = 1'b1;
        c.wb_sel    = 2'b00;
      end
      S_BRANCH: begin
        c.src_a  = 2'b01;
        c.src_b  = 2'b00;
        c.alu_op = ALU_BR;
        c.branch = 1'b1;
        c.pc_src = 2'b01;
      end
      S_JAL: begin
        c.pc_write  = 1'b1;
        c.pc_src    = 2'b01;
        c.reg_write = 1'b1;
        c.wb_sel    = 2'b10;
      end
      S_JALR: begin
        c.src_a     = 2'b01;
        c.src_b     = 2'b10;
        c.alu_op    = ALU_ADD;
        c.pc_write  = 1'b1;
        c.pc_src    = 2'b10;
        c.reg_write = 1'b1;
        c.wb_sel    = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    next_state  = state;
    mem_wait    = 1'b0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state)
      S_FETCH: begin
        mem_wait = 1'b1;
        if (Mem_Ready_i) next_state = S_DECODE;
      end
      S_DECODE: begin
        case (OP_i)
          OP_R:               next_state = S_EXEC_R;
          OP_I:               next_state = S_EXEC_I;
          OP_LUI:             next_state = S_EXEC_U;
          OP_LOAD, OP_STORE:  next_state = S_ADDR;
          OP_BRANCH:          next_state = S_BRANCH;
          OP_JAL:             next_state = S_JAL;
          OP_JALR:            next_state = S_JALR;
          default: begin
            next_state  = S_TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_EXEC_U: next_state = S_ALU_WB;
      S_ADDR:   next_state = (OP_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        mem_wait = 1'b1;
        if (Mem_Ready_i) next_state = S_MEM_WB;
      end
      S_MEM_WR: begin
        mem_wait = 1'b1;
        if (Mem_Ready_i) next_state = S_FETCH;
      end
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL, S_JALR: next_state = S_FETCH;
      S_TRAP:   next_state = S_TRAP;
      default: begin
        next_state  = S_TRAP;
        set_illegal = 1'b1;
      end
    endcase
    // A ready on the limit cycle wins; only a still-stalled memory times out.
    if (mem_wait && !Mem_Ready_i && (wait_cnt == WAIT_LIMIT)) begin
      next_state  = S_TRAP;
      set_timeout = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_FETCH;
      ctrl_q    <= decode_ctrl(S_FETCH);
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state  <= next_state;
      ctrl_q <= decode_ctrl(next_state);
      if (next_state != state) begin
        wait_cnt <= '0;
      end else if (mem_wait && !Mem_Ready_i) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (set_illegal) illegal_q <= 1'b1;
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  assign IR_Write_o  = ctrl_q.is_fetch & Mem_Ready_i;
  assign PC_Write_o  = ctrl_q.pc_write | (ctrl_q.is_fetch & Mem_Ready_i);
  assign Mem_Read_o  = ctrl_q.mem_read;
  assign Mem_Write_o = ctrl_q.mem_write;
  assign Reg_Write_o = ctrl_q.reg_write;
  assign Wb_Sel_o    = ctrl_q.wb_sel;
  assign ALU_Src_A_o = ctrl_q.src_a;
  assign ALU_Src_B_o = ctrl_q.src_b;
  assign ALU_Op_o    = ctrl_q.alu_op;
  assign PC_Src_o    = ctrl_q.pc_src;
  assign Branch_o    = ctrl_q.branch;
  assign Illegal_o   = illegal_q;
  assign Timeout_o   = timeout_q;
  assign State_o     = state;

`ifdef CONTROL_PERF_CNT_EN
  logic [31:0] instr_count;
  logic        retire;

  // An instruction retires when a completing state hands control back to FETCH.
  always_comb begin
    retire = 1'b0;
    if (next_state == S_FETCH) begin
      case (state)
        S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_JALR: retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_count <= '0;
    end else if (retire) begin
      instr_count <= instr_count + 32'd1;
    end
  end

  assign Instr_Count_o = instr_count;
`else
  assign Instr_Count_o = '0;
`endif

endmodule
